// File: rtl/bsg_chip_pkg.sv
`default_nettype none
// ============================================================================
// Module : bsg_chip_pkg
// Brief  : Shared defaults and helpers for the BedRock mem-command arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package bsg_chip_pkg;

  localparam int num_req_default         = 2;
  localparam int max_outstanding_default = 8;

  // A single requester still needs a one-bit id so the tag FIFO has width.
  function automatic int req_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int req_id_width_default = req_id_width(num_req_default);

  localparam logic [0:0] out_empty_st = 1'b0;
  localparam logic [0:0] out_full_st  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// Module : bsg_fifo_1r1w_small
// Brief  : Small circular-buffer FIFO, one push and one pop port, show-ahead.
// Rev    : 1.0  initial release
// ============================================================================
module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wr_ptr, rd_ptr;
  logic [cnt_w-1:0]   count;
  logic               push, pop;

  assign full_o  = (count == full_cnt);
  assign empty_o = (count == '0);
  assign push    = v_i & ~full_o;
  assign pop     = yumi_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bp_cce_mc_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bp_cce_mc_arbiter
// Brief  : Round-robin mux of BedRock mem commands onto one link, in-order
//          response return via a requester-id tag FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module bp_cce_mc_arbiter
  import bsg_chip_pkg::*;
#(
  parameter int num_req_p         = num_req_default,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = max_outstanding_default
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p-1:0][msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]                  cmd_v_i,
  output logic [num_req_p-1:0]                  cmd_ready_o,
  output logic [msg_width_p-1:0]                resp_o,
  output logic [num_req_p-1:0]                  resp_v_o,
  input  logic [num_req_p-1:0]                  resp_yumi_i,
  output logic [msg_width_p-1:0]                link_cmd_o,
  output logic                                  link_cmd_v_o,
  input  logic                                  link_cmd_ready_i,
  input  logic [msg_width_p-1:0]                link_resp_i,
  input  logic                                  link_resp_v_i,
  output logic                                  link_resp_yumi_o,
  output logic                                  error_o
);

  localparam int id_w = req_id_width(num_req_p);
  localparam logic [id_w:0] num_req_c = (id_w + 1)'(num_req_p);

  // Assertion is immediate; release waits two clocks.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [id_w-1:0]        prio, grant_id, head_id, next_prio;
  logic [id_w:0]          arb_sum;
  logic                   grant_found, can_accept, accept;
  logic                   fifo_full, fifo_empty, fifo_pop, resp_hit;
  logic [0:0]             out_state;
  logic [msg_width_p-1:0] out_msg;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = prio;
    arb_sum     = '0;
    for (int i = 0; i < num_req_p; i++) begin
      arb_sum = {1'b0, prio} + (id_w + 1)'(i);
      if (arb_sum >= num_req_c) arb_sum = arb_sum - num_req_c;
      if (!grant_found && cmd_v_i[arb_sum[id_w-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = arb_sum[id_w-1:0];
      end
    end
  end

  // A full tag FIFO blocks grants even when it pops in the same cycle.
  assign can_accept  = rst_n & ~fifo_full
                     & ((out_state == out_empty_st) | link_cmd_ready_i);
  assign accept      = grant_found & can_accept;
  assign cmd_ready_o = accept ? (num_req_p'(1) << grant_id) : '0;
  assign next_prio   = (({1'b0, grant_id} + 1'b1) >= num_req_c) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= '0;
      out_state <= out_empty_st;
      out_msg   <= '0;
    end else begin
      if (accept) begin
        prio      <= next_prio;
        out_state <= out_full_st;
        out_msg   <= cmd_i[grant_id];
      end else if (link_cmd_ready_i) begin
        out_state <= out_empty_st;
      end
    end
  end

  assign link_cmd_v_o = (out_state == out_full_st);
  assign link_cmd_o   = out_msg;

  bsg_fifo_1r1w_small #(
    .width_p (id_w),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (rst_n),
    .v_i       (accept),
    .data_i    (grant_id),
    .yumi_i    (fifo_pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .data_o    (head_id)
  );

  // Responses with no tag outstanding are swallowed and flagged.
  assign resp_hit         = link_resp_v_i & ~fifo_empty;
  assign resp_o           = link_resp_i;
  assign resp_v_o         = resp_hit ? (num_req_p'(1) << head_id) : '0;
  assign link_resp_yumi_o = rst_n & link_resp_v_i & (fifo_empty | resp_yumi_i[head_id]);
  assign fifo_pop         = link_resp_yumi_o & ~fifo_empty;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                            error_o <= 1'b0;
    else if (link_resp_v_i && fifo_empty)  error_o <= 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/bp_cce_mc_arbiter.md
BP_CCE_MC_ARBITER -- requirements
Module: bp_cce_mc_arbiter

Interface
REQ-001 Parameter num_req_p, default 2: number of upstream BedRock mem-command requesters sharing one manycore link adapter.
REQ-002 Parameter msg_width_p, default 128: width of one packed bp_bedrock mem message, header plus payload.
REQ-003 Parameter max_outstanding_p, default 8: maximum number of commands issued downstream and not yet answered.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  asynchronous, active-low reset.
REQ-006 cmd_i  input  [num_req_p][msg_width_p]  per-requester command message.
REQ-007 cmd_v_i  input  [num_req_p]  per-requester command valid.
REQ-008 cmd_ready_o  output  [num_req_p]  per-requester ready; the handshake is cmd_v_i & cmd_ready_o.
REQ-009 resp_o  output  [msg_width_p]  response message, broadcast to all requesters.
REQ-010 resp_v_o  output  [num_req_p]  response valid; at most one bit is set.
REQ-011 resp_yumi_i  input  [num_req_p]  per-requester response consume.
REQ-012 link_cmd_o  output  [msg_width_p]  command message to the downstream link adapter.
REQ-013 link_cmd_v_o  output  1  downstream command valid.
REQ-014 link_cmd_ready_i  input  1  downstream ready; the handshake is link_cmd_v_o & link_cmd_ready_i.
REQ-015 link_resp_i  input  [msg_width_p]  downstream response message.
REQ-016 link_resp_v_i  input  1  downstream response valid.
REQ-017 link_resp_yumi_o  output  1  downstream response consume.
REQ-018 error_o  output  1  sticky flag: a response arrived with no command outstanding.

Function
REQ-019 The arbiter SHALL be round-robin: the requester granted last cycle has lowest priority next cycle, and the pointer moves only on an accepted command.
REQ-020 At most one cmd_ready_o bit SHALL be high per cycle, and only for the highest-priority requester with cmd_v_i high.
REQ-021 That grant SHALL be given only when the output register is empty or draining this cycle, and the tag FIFO is not full.
REQ-022 The output register SHALL have two states, EMPTY and FULL.
- EMPTY->FULL on accept.
- FULL->EMPTY on downstream handshake with no new accept.
- FULL->FULL on simultaneous drain and accept.
REQ-023 Accept-to-link_cmd_v_o latency SHALL be exactly 1 cycle; link_cmd_o SHALL hold stable while link_cmd_v_o is high and link_cmd_ready_i is low.
REQ-024 On accept, the requester index (clog2(num_req_p) bits) SHALL be pushed into the tag FIFO in the same cycle.
REQ-025 Downstream responses SHALL be treated as strictly in command order; each SHALL be routed to the requester at the tag FIFO head.
- resp_o = link_resp_i.
- resp_v_o[head] = link_resp_v_i & tag FIFO not empty.
- link_resp_yumi_o = resp_yumi_i[head].
REQ-026 The tag FIFO SHALL pop only on link_resp_yumi_o.
REQ-027 A full tag FIFO SHALL block all grants even if a pop occurs the same cycle; full-to-push bypass is prohibited.
REQ-028 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged.
REQ-029 A link_resp_v_i arriving with the tag FIFO empty SHALL be consumed (link_resp_yumi_o=1), drive no resp_v_o bit, and set error_o until reset.
REQ-030 Requester order across the arbiter SHALL be preserved per requester; no reordering of responses is permitted.

Reset
REQ-031 While reset_i=0, the block SHALL hold these values:
- cmd_ready_o=0, resp_v_o=0, link_cmd_v_o=0, link_resp_yumi_o=0, error_o=0.
- Output register EMPTY, tag FIFO empty, round-robin pointer at requester 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight commands and tags without completing them; recovering any downstream state is the system's responsibility.
REQ-033 Reset deassertion SHALL be synchronized internally before it releases state.

Structure
REQ-034 The package bsg_chip_pkg SHALL hold the default max_outstanding and the requester-id width localparam derived from num_req_p.
REQ-035 The tag FIFO SHALL be a single sub-module, bsg_fifo_1r1w_small, of depth max_outstanding_p; the arbitration logic SHALL be inline.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Both requesters valid continuously, link always ready -> grants alternate 0,1,0,1; link_cmd_v_o lags each accept by 1 cycle.
- Req0 issues 8 commands with no responses -> the 9th is held (cmd_ready_o=0); one response pops the FIFO, and the grant resumes the next cycle.
- Issue order 1,0,1; responses returned in order -> resp_v_o one-hot sequence 2'b10, 2'b01, 2'b10.
- link_cmd_ready_i low for 5 cycles -> link_cmd_o stable and no further grant; then ready and a new accept in the same cycle -> output register stays FULL with the new message.
- Response with no command outstanding -> link_resp_yumi_o=1, resp_v_o=0, error_o=1 until reset.
- reset_i pulled low with 3 commands outstanding -> all outputs 0 immediately; after release the FIFO is empty and the pointer is at requester 0.
